// File: rtl/control_multiciclo_pkg.sv
// Shared encodings for the multicycle RV32I control unit: opcodes, FSM states,
// datapath select codes and the immediate-format helpers.
package control_multiciclo_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [3:0] EXT_I     = 4'd0;
    localparam logic [3:0] EXT_S     = 4'd1;
    localparam logic [3:0] EXT_B     = 4'd2;
    localparam logic [3:0] EXT_U     = 4'd3;
    localparam logic [3:0] EXT_J     = 4'd4;
    localparam logic [3:0] EXT_SHAMT = 4'd5;
    localparam logic [3:0] EXT_NONE  = 4'hF;

    localparam logic [1:0] PC_SRC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_SRC_ALU   = 2'd1;
    localparam logic [1:0] PC_SRC_JALR  = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    localparam logic [1:0] SRC_A_RS1  = 2'd0;
    localparam logic [1:0] SRC_A_PC   = 2'd1;
    localparam logic [1:0] SRC_A_ZERO = 2'd2;
    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_IMM  = 2'd1;
    localparam logic [1:0] SRC_B_FOUR = 2'd2;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    function automatic logic is_legal_opcode(input logic [6:0] opcode);
        case (opcode)
            OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
            OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] ext_sel_for(input logic [6:0] opcode, input logic [2:0] funct3);
        case (opcode)
            OPC_OP_IMM:         return ((funct3 == 3'b001) || (funct3 == 3'b101)) ? EXT_SHAMT : EXT_I;
            OPC_LOAD, OPC_JALR: return EXT_I;
            OPC_STORE:          return EXT_S;
            OPC_BRANCH:         return EXT_B;
            OPC_LUI, OPC_AUIPC: return EXT_U;
            OPC_JAL:            return EXT_J;
            default:            return EXT_NONE;
        endcase
    endfunction

    // The ALU runs SUB for eq/ne and SLT/SLTU for the ordered compares.
    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
        case (funct3)
            3'b000, 3'b101, 3'b111: return zero;
            3'b001, 3'b100, 3'b110: return !zero;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_multiciclo_decodificador_alu.sv
// Combinational ALU operation decoder driven by the latched instruction fields.
module decodificador_alu
    import control_multiciclo_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output logic [3:0] alu_op
);

    // Map opcode/funct3/funct7 to the ALU operation
    always_comb begin
        alu_op = ALU_ADD;
        case (opcode)
            OPC_OP, OPC_OP_IMM: begin
                case (funct3)
                    3'b000: begin
                        if ((opcode == OPC_OP) && funct7_b5) begin
                            alu_op = ALU_SUB;
                        end else begin
                            alu_op = ALU_ADD;
                        end
                    end
                    3'b001:  alu_op = ALU_SLL;
                    3'b010:  alu_op = ALU_SLT;
                    3'b011:  alu_op = ALU_SLTU;
                    3'b100:  alu_op = ALU_XOR;
                    3'b101:  alu_op = funct7_b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_op = ALU_OR;
                    3'b111:  alu_op = ALU_AND;
                    default: alu_op = ALU_ADD;
                endcase
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b100, 3'b101: alu_op = ALU_SLT;
                    3'b110, 3'b111: alu_op = ALU_SLTU;
                    default:        alu_op = ALU_SUB;
                endcase
            end
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// sticky TRAP on unsupported opcodes.
module control_multiciclo
    import control_multiciclo_pkg::*;
#(
    parameter int RESET_STATE_WAIT = 0
)
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] instr_in,
    input  logic        mem_ready,
    input  logic        alu_zero,
    output logic [31:0] COD,
    output logic [3:0]  ext_sel,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_op,
    output logic        illegal
);

    localparam int WAIT_W = (RESET_STATE_WAIT > 0) ? $clog2(RESET_STATE_WAIT + 1) : 1;

    state_t             state_r, next_state_s;
    logic [31:0]        cod_r;
    logic [3:0]         ext_sel_r;
    logic               illegal_r;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic               fetch_done_s;
    logic               mem_req_s, mem_we_s, addr_sel_s, pc_we_s, reg_we_s;
    logic [1:0]         pc_src_s, wb_sel_s, alu_src_a_s, alu_src_b_s;
    logic [6:0]         opcode_s;
    logic [2:0]         funct3_s;
    logic [4:0]         rd_s;

    assign opcode_s = cod_r[6:0];
    assign funct3_s = cod_r[14:12];
    assign rd_s     = cod_r[11:7];

    decodificador_alu u_decodificador_alu (
        .opcode    (opcode_s),
        .funct3    (funct3_s),
        .funct7_b5 (cod_r[30]),
        .alu_op    (alu_op)
    );

    // State register, instruction register, immediate format and sticky trap flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_FETCH;
            cod_r      <= NOP_INSTR;
            ext_sel_r  <= EXT_NONE;
            illegal_r  <= 1'b0;
            wait_cnt_r <= WAIT_W'(RESET_STATE_WAIT);
        end else begin
            state_r <= next_state_s;
            if (fetch_done_s) begin
                // Format is captured with the word so it is already valid in DECODE.
                cod_r     <= instr_in;
                ext_sel_r <= ext_sel_for(instr_in[6:0], instr_in[14:12]);
            end
            if (next_state_s == ST_TRAP) begin
                illegal_r <= 1'b1;
            end
            if (wait_cnt_r != '0) begin
                wait_cnt_r <= wait_cnt_r - WAIT_W'(1);
            end
        end
    end

    // Next-state and control outputs; everything stays quiet while reset is held
    always_comb begin
        next_state_s = state_r;
        fetch_done_s = 1'b0;
        mem_req_s    = 1'b0;
        mem_we_s     = 1'b0;
        addr_sel_s   = 1'b0;
        pc_we_s      = 1'b0;
        pc_src_s     = PC_SRC_PLUS4;
        reg_we_s     = 1'b0;
        wb_sel_s     = WB_ALU;
        alu_src_a_s  = SRC_A_RS1;
        alu_src_b_s  = SRC_B_RS2;
        if (!reset_n) begin
            next_state_s = ST_FETCH;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (wait_cnt_r != '0) begin
                        next_state_s = ST_FETCH;
                    end else begin
                        mem_req_s = 1'b1;
                        if (mem_ready) begin
                            fetch_done_s = 1'b1;
                            pc_we_s      = 1'b1;
                            pc_src_s     = PC_SRC_PLUS4;
                            next_state_s = ST_DECODE;
                        end else begin
                            next_state_s = ST_FETCH;
                        end
                    end
                end
                ST_DECODE: begin
                    if (is_legal_opcode(opcode_s)) begin
                        next_state_s = ST_EXEC;
                    end else begin
                        next_state_s = ST_TRAP;
                    end
                end
                ST_EXEC: begin
                    next_state_s = ST_WB;
                    case (opcode_s)
                        OPC_OP: begin
                            alu_src_a_s = SRC_A_RS1;
                            alu_src_b_s = SRC_B_RS2;
                        end
                        OPC_OP_IMM, OPC_JALR: begin
                            alu_src_a_s = SRC_A_RS1;
                            alu_src_b_s = SRC_B_IMM;
                        end
                        OPC_LOAD, OPC_STORE: begin
                            alu_src_a_s  = SRC_A_RS1;
                            alu_src_b_s  = SRC_B_IMM;
                            next_state_s = ST_MEM;
                        end
                        OPC_AUIPC, OPC_JAL: begin
                            alu_src_a_s = SRC_A_PC;
                            alu_src_b_s = SRC_B_IMM;
                        end
                        OPC_LUI: begin
                            alu_src_a_s = SRC_A_ZERO;
                            alu_src_b_s = SRC_B_IMM;
                        end
                        OPC_BRANCH: begin
                            alu_src_a_s  = SRC_A_RS1;
                            alu_src_b_s  = SRC_B_RS2;
                            next_state_s = ST_FETCH;
                            if (branch_taken(funct3_s, alu_zero)) begin
                                pc_we_s  = 1'b1;
                                pc_src_s = PC_SRC_ALU;
                            end else begin
                                pc_we_s  = 1'b0;
                            end
                        end
                        default: next_state_s = ST_TRAP;
                    endcase
                end
                ST_MEM: begin
                    mem_req_s  = 1'b1;
                    addr_sel_s = 1'b1;
                    mem_we_s   = (opcode_s == OPC_STORE);
                    if (mem_ready) begin
                        next_state_s = (opcode_s == OPC_STORE) ? ST_FETCH : ST_WB;
                    end else begin
                        next_state_s = ST_MEM;
                    end
                end
                ST_WB: begin
                    next_state_s = ST_FETCH;
                    reg_we_s     = (rd_s != 5'd0);
                    case (opcode_s)
                        OPC_LOAD: wb_sel_s = WB_MEM;
                        OPC_LUI:  wb_sel_s = WB_IMM;
                        OPC_JAL: begin
                            wb_sel_s = WB_PC4;
                            pc_we_s  = 1'b1;
                            pc_src_s = PC_SRC_ALU;
                        end
                        OPC_JALR: begin
                            wb_sel_s = WB_PC4;
                            pc_we_s  = 1'b1;
                            pc_src_s = PC_SRC_JALR;
                        end
                        default: wb_sel_s = WB_ALU;
                    endcase
                end
                ST_TRAP: next_state_s = ST_TRAP;
                default: next_state_s = ST_TRAP;
            endcase
        end
    end

    assign COD       = cod_r;
    assign ext_sel   = ext_sel_r;
    assign illegal   = illegal_r;
    assign mem_req   = mem_req_s;
    assign mem_we    = mem_we_s;
    assign addr_sel  = addr_sel_s;
    assign pc_we     = pc_we_s;
    assign pc_src    = pc_src_s;
    assign reg_we    = reg_we_s;
    assign wb_sel    = wb_sel_s;
    assign alu_src_a = alu_src_a_s;
    assign alu_src_b = alu_src_b_s;

endmodule

// File: tb/tb_control_multiciclo.sv
// Randomized bench: a per-instruction cycle plan derived from the instruction
// semantics and latency rules is compared against the DUT on every cycle.
module tb_control_multiciclo;
    import control_multiciclo_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n, mem_ready, alu_zero;
    logic [31:0] instr_in, COD;
    logic [3:0]  ext_sel, alu_op;
    logic        mem_req, mem_we, addr_sel, pc_we, reg_we, illegal;
    logic [1:0]  pc_src, wb_sel, alu_src_a, alu_src_b;

    control_multiciclo dut (
        .clock(clock), .reset_n(reset_n), .instr_in(instr_in), .mem_ready(mem_ready),
        .alu_zero(alu_zero), .COD(COD), .ext_sel(ext_sel), .mem_req(mem_req),
        .mem_we(mem_we), .addr_sel(addr_sel), .pc_we(pc_we), .pc_src(pc_src),
        .reg_we(reg_we), .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .illegal(illegal)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rdy;
        logic [31:0] instr;
        logic        zero;
        logic        mem_req, mem_we, addr_sel, pc_we, reg_we;
        logic [1:0]  pc_src, wb_sel, src_a, src_b;
        logic        in_exec, in_wb;
        logic [3:0]  alu, ext;
        logic [31:0] cod;
        logic        ill;
    } cyc_t;

    cyc_t        plan[$];
    logic [31:0] m_cod;
    logic [3:0]  m_ext;
    logic        m_ill;
    int          pass_cnt = 0, total_cnt = 0;
    int          last_regwe, last_pcwe;
    logic [1:0]  obs_wb;
    logic [3:0]  obs_ext;

    logic [6:0] legal_ops [9] = '{OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                                  OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC};
    logic [2:0] br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic is_legal_m(input logic [6:0] opc);
        foreach (legal_ops[i]) if (legal_ops[i] == opc) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] model_ext(input logic [6:0] opc, input logic [2:0] f3);
        if (opc == OPC_OP_IMM) return ((f3 == 3'd1) || (f3 == 3'd5)) ? 4'd5 : 4'd0;
        if (opc == OPC_LOAD || opc == OPC_JALR) return 4'd0;
        if (opc == OPC_STORE) return 4'd1;
        if (opc == OPC_BRANCH) return 4'd2;
        if (opc == OPC_LUI || opc == OPC_AUIPC) return 4'd3;
        if (opc == OPC_JAL) return 4'd4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] model_alu(input logic [6:0] opc, input logic [2:0] f3, input logic b30);
        logic [3:0] ops [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        if (opc == OPC_OP || opc == OPC_OP_IMM) begin
            if (f3 == 3'd0 && opc == OPC_OP && b30) return ALU_SUB;
            if (f3 == 3'd5 && b30) return ALU_SRA;
            return ops[f3];
        end
        if (opc == OPC_BRANCH) return f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        return ALU_ADD;
    endfunction

    function automatic logic model_taken(input logic [2:0] f3, input logic z);
        if (f3 == 3'd0 || f3 == 3'd5 || f3 == 3'd7) return z;
        if (f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd6) return !z;
        return 1'b0;
    endfunction

    function automatic cyc_t blank();
        cyc_t c;
        c.rdy = 1'($urandom); c.instr = $urandom; c.zero = 1'($urandom);
        c.mem_req = 1'b0; c.mem_we = 1'b0; c.addr_sel = 1'b0; c.pc_we = 1'b0; c.reg_we = 1'b0;
        c.pc_src = 2'd0; c.wb_sel = 2'd0; c.src_a = 2'd0; c.src_b = 2'd0;
        c.in_exec = 1'b0; c.in_wb = 1'b0; c.alu = 4'd0;
        c.cod = m_cod; c.ext = m_ext; c.ill = m_ill;
        return c;
    endfunction

    // Expected cycle sequence for one instruction given fetch/memory wait counts.
    task automatic plan_instr(input logic [31:0] ins, input int fw, input int mw, input logic zero);
        cyc_t c;
        logic [6:0] opc = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        for (int i = 0; i < fw; i++) begin
            c = blank(); c.rdy = 1'b0; c.mem_req = 1'b1; plan.push_back(c);
        end
        c = blank(); c.rdy = 1'b1; c.instr = ins; c.mem_req = 1'b1; c.pc_we = 1'b1; c.pc_src = 2'd0;
        plan.push_back(c);
        m_cod = ins; m_ext = model_ext(opc, f3);
        plan.push_back(blank());
        if (!is_legal_m(opc)) begin
            m_ill = 1'b1;
            repeat (3) plan.push_back(blank());
            return;
        end
        c = blank(); c.in_exec = 1'b1; c.alu = model_alu(opc, f3, ins[30]);
        if (opc == OPC_OP || opc == OPC_BRANCH) begin c.src_a = 2'd0; c.src_b = 2'd0; end
        else if (opc == OPC_AUIPC || opc == OPC_JAL) begin c.src_a = 2'd1; c.src_b = 2'd1; end
        else if (opc == OPC_LUI) begin c.src_a = 2'd2; c.src_b = 2'd1; end
        else begin c.src_a = 2'd0; c.src_b = 2'd1; end
        if (opc == OPC_BRANCH) begin
            c.zero = zero; c.pc_we = model_taken(f3, zero); c.pc_src = 2'd1;
            plan.push_back(c);
            return;
        end
        plan.push_back(c);
        if (opc == OPC_LOAD || opc == OPC_STORE) begin
            for (int i = 0; i <= mw; i++) begin
                c = blank(); c.rdy = (i == mw); c.mem_req = 1'b1; c.addr_sel = 1'b1;
                c.mem_we = (opc == OPC_STORE); plan.push_back(c);
            end
            if (opc == OPC_STORE) return;
        end
        c = blank(); c.in_wb = 1'b1; c.reg_we = (ins[11:7] != 5'd0);
        if (opc == OPC_LOAD) c.wb_sel = 2'd1;
        else if (opc == OPC_LUI) c.wb_sel = 2'd3;
        else if (opc == OPC_JAL || opc == OPC_JALR) begin
            c.wb_sel = 2'd2; c.pc_we = 1'b1; c.pc_src = (opc == OPC_JAL) ? 2'd1 : 2'd2;
        end else c.wb_sel = 2'd0;
        plan.push_back(c);
    endtask

    task automatic compare(input cyc_t c);
        chk("mem_req", 32'(mem_req), 32'(c.mem_req));
        chk("mem_we", 32'(mem_we), 32'(c.mem_we));
        chk("addr_sel", 32'(addr_sel), 32'(c.addr_sel));
        chk("pc_we", 32'(pc_we), 32'(c.pc_we));
        chk("reg_we", 32'(reg_we), 32'(c.reg_we));
        chk("COD", COD, c.cod);
        chk("ext_sel", 32'(ext_sel), 32'(c.ext));
        chk("illegal", 32'(illegal), 32'(c.ill));
        if (c.pc_we) chk("pc_src", 32'(pc_src), 32'(c.pc_src));
        if (c.in_wb) chk("wb_sel", 32'(wb_sel), 32'(c.wb_sel));
        if (c.in_exec) begin
            chk("alu_src_a", 32'(alu_src_a), 32'(c.src_a));
            chk("alu_src_b", 32'(alu_src_b), 32'(c.src_b));
            chk("alu_op", 32'(alu_op), 32'(c.alu));
        end
    endtask

    // Drive each planned cycle on the falling edge and compare 1 ns later.
    task automatic run_plan(input int max_n);
        cyc_t c;
        int idx = 0;
        last_regwe = 0; last_pcwe = 0;
        while (plan.size() > 0 && idx < max_n) begin
            c = plan.pop_front(); idx++;
            @(negedge clock);
            mem_ready = c.rdy; instr_in = c.instr; alu_zero = c.zero;
            #1;
            compare(c);
            if (reg_we) begin last_regwe = idx; obs_wb = wb_sel; end
            if (pc_we) last_pcwe = idx;
            if (idx == 2) obs_ext = ext_sel;
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_pc_we", 32'(pc_we), 32'd0);
        chk("rst_reg_we", 32'(reg_we), 32'd0);
        chk("rst_addr_sel", 32'(addr_sel), 32'd0);
        chk("rst_selects", {24'd0, pc_src, wb_sel, alu_src_a, alu_src_b}, 32'd0);
        chk("rst_COD", COD, 32'h0000_0013);
        chk("rst_ext_sel", 32'(ext_sel), 32'hF);
        chk("rst_illegal", 32'(illegal), 32'd0);
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset_n = 1'b1; mem_ready = 1'b0;
        m_cod = 32'h0000_0013; m_ext = 4'hF; m_ill = 1'b0;
    endtask

    // Asynchronous reset mid-cycle, away from any clock edge.
    task automatic do_reset();
        #2;
        mem_ready = 1'b1; reset_n = 1'b0;
        #1;
        check_reset_outputs();
        plan.delete();
        release_reset();
    endtask

    function automatic logic [31:0] rand_instr(input int kind);
        logic [31:0] ins = $urandom;
        logic [6:0]  opc;
        if (kind < 9) opc = legal_ops[kind];
        else begin
            do opc = 7'($urandom); while (is_legal_m(opc));
        end
        ins[6:0] = opc;
        if (opc == OPC_BRANCH) ins[14:12] = br_f3[$urandom_range(0, 5)];
        if ($urandom_range(0, 3) == 0) ins[11:7] = 5'd0;
        return ins;
    endfunction

    initial begin
        reset_n = 1'b0; mem_ready = 1'b1; instr_in = 32'd0; alu_zero = 1'b0;
        m_cod = 32'h0000_0013; m_ext = 4'hF; m_ill = 1'b0;
        @(posedge clock); #1;
        check_reset_outputs();
        release_reset();

        // addi x1,x0,5
        plan_instr(32'h0050_0093, 0, 0, 1'b0);
        chk("addi_len", plan.size(), 32'd4);
        run_plan(100);
        chk("addi_regwe_cycle", last_regwe, 32'd4);
        chk("addi_wb_sel", 32'(obs_wb), 32'd0);
        chk("addi_ext_sel", 32'(obs_ext), 32'd0);

        // lw x5,0(x1) with two memory wait cycles
        plan_instr(32'h0000_A283, 0, 2, 1'b0);
        chk("lw_len", plan.size(), 32'd7);
        run_plan(100);
        chk("lw_regwe_cycle", last_regwe, 32'd7);
        chk("lw_wb_sel", 32'(obs_wb), 32'd1);

        // beq x1,x2,8 taken and not taken
        plan_instr(32'h0020_8463, 0, 0, 1'b1);
        chk("beq_len", plan.size(), 32'd3);
        run_plan(100);
        chk("beq_taken_pcwe_cycle", last_pcwe, 32'd3);
        plan_instr(32'h0020_8463, 0, 0, 1'b0);
        run_plan(100);
        chk("beq_not_taken_pcwe_cycle", last_pcwe, 32'd1);

        for (int n = 0; n < 120; n++) begin
            int kind = $urandom_range(0, 10);
            plan_instr(rand_instr(kind), $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
            run_plan(100);
            if (kind >= 9) begin
                chk("rand_trap_illegal", 32'(illegal), 32'd1);
                do_reset();
            end
        end

        // opcode 0 traps; no memory request afterwards
        plan_instr(32'h0000_0000, 0, 0, 1'b0);
        run_plan(100);
        chk("trap_illegal", 32'(illegal), 32'd1);
        do_reset();

        // sw x2,4(x1) interrupted by reset in its first MEM wait cycle
        plan_instr(32'h0020_A223, 0, 3, 1'b0);
        run_plan(4);
        chk("sw_mem_we_before_reset", 32'(mem_we), 32'd1);
        do_reset();
        plan_instr(32'h0050_0093, 0, 0, 1'b0);
        run_plan(100);
        chk("restart_regwe_cycle", last_regwe, 32'd4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
